fifo_burst_reader: RTL and testbench
====================================

Name: fifo_burst_reader

Overview:
Read-side controller for buffer_fifo_configurable. It pops a configured burst of bytes from the FIFO and presents them to the downstream filter stage on a valid/ready stream. The FIFO has no empty flag, so the block tracks FIFO occupancy by snooping the writer's push strobe, and it never pops an empty FIFO.

Parameters:
DATA_WIDTH, 8, width of FIFO words and of the output stream
DEPTH, 256, FIFO capacity in words; the level counter saturates at this value
CFG_WIDTH, 3, width of the burst-length code
LVL_WIDTH, 9, width of the level counter; must satisfy 2^LVL_WIDTH > DEPTH

Ports:
clk  in  1  system clock; all logic is on the rising edge
reset  in  1  asynchronous, active-low reset
configuration  in  CFG_WIDTH  burst-length code; burst length = 2^configuration (1..128)
save_config  in  1  single-cycle strobe that latches configuration
fifo_push  in  1  snooped copy of the writer's push to the FIFO
fifo_full  in  1  buffer_full from the FIFO
fifo_no_config  in  1  no_config from the FIFO
fifo_data  in  DATA_WIDTH  data_out from the FIFO
fifo_pop  out  1  pop strobe to the FIFO
start  in  1  single-cycle request for one burst
out_data  out  DATA_WIDTH  stream data
out_valid  out  1  stream valid
out_ready  in  1  downstream ready
busy  out  1  high while a burst is in progress
burst_done  out  1  one-cycle pulse after the last beat of a burst is accepted
cfg_missing  out  1  high until a configuration has been saved
level  out  LVL_WIDTH  tracked FIFO occupancy

Behaviour:
- Reset (asynchronous, active-low): fifo_pop=0, out_valid=0, out_data=0, busy=0, burst_done=0, cfg_missing=1, level=0, state=IDLE, latched config=0. A reset mid-burst aborts the burst immediately with no completion pulse.
- Configuration:
  - save_config in IDLE latches configuration and clears cfg_missing.
  - save_config while busy is ignored.
- Level tracking:
  - Increment on fifo_push && !fifo_full.
  - Decrement on fifo_pop.
  - Both in the same cycle: level unchanged.
  - Saturate at DEPTH and at 0; never wrap.
- Start acceptance: start is accepted only in IDLE with cfg_missing=0 and fifo_no_config=0. Otherwise it is dropped, with no queuing.
- FSM transitions:
  - IDLE -> POP on an accepted start. Load beat counter = 2^cfg; busy=1.
  - POP: if level>0, assert fifo_pop for exactly 1 cycle, then -> CAPT. If level==0, hold in POP with fifo_pop=0 (starved).
  - CAPT: fifo_data is valid this cycle (FIFO read latency is 1). Register it into out_data, set out_valid=1, -> HOLD.
  - HOLD: out_valid and out_data stay stable until out_ready=1. On the handshake, decrement the beat counter.
    - If the count is nonzero -> POP.
    - Otherwise -> IDLE with burst_done=1 for 1 cycle and busy=0 in that same cycle.
- Timing and throughput:
  - Minimum 3 cycles per beat.
  - Start-to-first out_valid latency is 2 cycles when level>0.
  - Pop issues at most one strobe per beat, and never while out_valid=1.
- fifo_no_config rising mid-burst does not abort the burst; the burst completes normally.
- out_ready while out_valid=0 has no effect.

Decomposition:
- Shared package/header fifo_reader_pkg:
  - FSM state encodings IDLE/POP/CAPT/HOLD
  - default DATA_WIDTH/DEPTH/CFG_WIDTH
  - burst-length function 1<<cfg
- One sub-module, fifo_level_tracker: the saturating up/down occupancy counter. Inputs are inc, dec and full; output is level. fifo_burst_reader instantiates it.

Test Plan:
- No config saved; start pulse -> fifo_pop stays 0, busy stays 0, cfg_missing=1.
- Configure with cfg=2 (burst 4); snoop 6 pushes of 0x01..0x06; start with out_ready=1 -> exactly 4 fifo_pop pulses; out_data beats 0x01..0x04; burst_done pulses once; level=2.
- Backpressure: out_ready=0 for 5 cycles during a beat -> out_valid held, out_data unchanged, no extra fifo_pop; the beat completes on out_ready=1.
- Starvation: cfg=3 (burst 8) with level=3; start -> 3 beats, then fifo_pop=0 and busy=1; push 5 more -> remaining 5 beats complete; level=0.
- Level boundaries:
  - 260 snooped pushes, with fifo_full=1 after 256 -> level=256.
  - fifo_push and fifo_pop in the same cycle -> level unchanged.
  - save_config with cfg=5 while busy -> burst length unchanged.
- Assert reset low mid-HOLD -> in the same cycle, out_valid=0, busy=0, level=0, cfg_missing=1, and no burst_done pulse.

Source files
------------

// File: rtl/fifo_reader_pkg.sv
// Shared FSM encoding, default sizing and burst-length helper for the FIFO burst reader.
// Pure declarations; no latency or backpressure of its own.
package fifo_reader_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH      = 256;
  localparam int DEF_CFG_WIDTH  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    CAPT = 2'd2,
    HOLD = 2'd3
  } state_t;

  function automatic int unsigned burst_len(input int unsigned cfg);
    return 32'd1 << cfg;
  endfunction

endpackage

// File: rtl/fifo_level_tracker.sv
// Saturating up/down occupancy counter fed by the snooped push and our own pop.
// One-cycle update latency; no backpressure, saturates at 0 and DEPTH instead of wrapping.
module fifo_level_tracker
  import fifo_reader_pkg::*;
#(
  parameter int DEPTH     = DEF_DEPTH,
  parameter int LVL_WIDTH = 9
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inc,
  input  logic                 dec,
  input  logic                 full,
  output logic [LVL_WIDTH-1:0] level
);

  logic up;
  logic at_max;
  logic at_min;

  // A push the FIFO refused never reached storage, so it must not be counted.
  assign up     = inc && !full;
  assign at_max = (level == LVL_WIDTH'(DEPTH));
  assign at_min = (level == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level <= '0;
    end else if (up && !dec && !at_max) begin
      level <= level + LVL_WIDTH'(1);
    end else if (dec && !up && !at_min) begin
      level <= level - LVL_WIDTH'(1);
    end
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// Pops a 2^cfg-beat burst from an un-flagged FIFO and streams it out on valid/ready.
// 2 cycles start-to-first valid, >=3 cycles per beat; out_ready low holds the beat and stalls further pops.
module fifo_burst_reader
  import fifo_reader_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int CFG_WIDTH  = DEF_CFG_WIDTH,
  parameter int LVL_WIDTH  = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CFG_WIDTH-1:0]  configuration,
  input  logic                  save_config,
  input  logic                  fifo_push,
  input  logic                  fifo_full,
  input  logic                  fifo_no_config,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_pop,
  input  logic                  start,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  burst_done,
  output logic                  cfg_missing,
  output logic [LVL_WIDTH-1:0]  level
);

  // Wide enough for the largest burst, 2^(2^CFG_WIDTH - 1).
  localparam int BEAT_W = 1 << CFG_WIDTH;

  state_t                state;
  state_t                state_nxt;
  logic [CFG_WIDTH-1:0]  cfg_q;
  logic [BEAT_W-1:0]     beat_cnt;
  logic [BEAT_W-1:0]     beat_cnt_nxt;
  logic                  burst_done_nxt;
  logic                  accept;
  logic                  last_beat;

  assign accept    = start && !cfg_missing && !fifo_no_config;
  assign last_beat = (beat_cnt == BEAT_W'(1));
  assign out_valid = (state == HOLD);
  assign busy      = (state != IDLE);

  fifo_level_tracker #(
    .DEPTH     (DEPTH),
    .LVL_WIDTH (LVL_WIDTH)
  ) u_level (
    .clk   (clk),
    .reset (reset),
    .inc   (fifo_push),
    .dec   (fifo_pop),
    .full  (fifo_full),
    .level (level)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    beat_cnt_nxt   = beat_cnt;
    fifo_pop       = 1'b0;
    burst_done_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt    = POP;
          beat_cnt_nxt = BEAT_W'(burst_len(32'(cfg_q)));
        end
      end
      POP: begin
        // Starved: wait for the writer rather than pop an empty FIFO.
        if (level != '0) begin
          fifo_pop  = 1'b1;
          state_nxt = CAPT;
        end
      end
      CAPT: state_nxt = HOLD;
      HOLD: begin
        if (out_ready) begin
          beat_cnt_nxt = beat_cnt - BEAT_W'(1);
          if (last_beat) begin
            state_nxt      = IDLE;
            burst_done_nxt = 1'b1;
          end else begin
            state_nxt = POP;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cfg_q       <= '0;
      cfg_missing <= 1'b1;
      beat_cnt    <= '0;
      out_data    <= '0;
      burst_done  <= 1'b0;
    end else begin
      if (save_config && (state == IDLE)) begin
        cfg_q       <= configuration;
        cfg_missing <= 1'b0;
      end
      // FIFO read data is valid the cycle after the pop strobe.
      if (state == CAPT) begin
        out_data <= fifo_data;
      end
      beat_cnt   <= beat_cnt_nxt;
      burst_done <= burst_done_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Scoreboard bench: pushes are recorded as expected beats, a monitor checks every accepted beat in order.
module tb_fifo_burst_reader;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] configuration;
  logic       save_config;
  logic       fifo_push;
  logic       fifo_full;
  logic       fifo_no_config;
  logic [7:0] fifo_data = '0;
  logic       fifo_pop;
  logic       start;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       busy;
  logic       burst_done;
  logic       cfg_missing;
  logic [8:0] level;

  int vectors    = 0;
  int miscompares = 0;

  // FIFO model storage and scoreboard of expected beats (pushed data, in order)
  logic [7:0]  fmem    [0:4095];
  logic [7:0]  exp_mem [0:4095];
  logic [11:0] fwr = '0, frd = '0, ewr = '0, erd = '0;
  logic [7:0]  wr_dat = '0;
  int pop_cnt  = 0;
  int beat_cnt = 0;
  int done_cnt = 0;
  int ready_mode = 0;
  int mlevel = 0;

  fifo_burst_reader dut (
    .clk            (clk),
    .reset          (reset),
    .configuration  (configuration),
    .save_config    (save_config),
    .fifo_push      (fifo_push),
    .fifo_full      (fifo_full),
    .fifo_no_config (fifo_no_config),
    .fifo_data      (fifo_data),
    .fifo_pop       (fifo_pop),
    .start          (start),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .busy           (busy),
    .burst_done     (burst_done),
    .cfg_missing    (cfg_missing),
    .level          (level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // FIFO behavioural model: one-cycle read latency, refuses pushes while full
  initial begin
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        frd       <= fwr;
        fifo_data <= '0;
      end else begin
        if (fifo_pop) begin
          fifo_data <= fmem[frd];
          frd       <= frd + 12'd1;
          pop_cnt   <= pop_cnt + 1;
        end
        if (fifo_push && !fifo_full) begin
          fmem[fwr] <= wr_dat;
          fwr       <= fwr + 12'd1;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: beat order, hold stability, pop legality, done pulse shape
  initial begin
    logic       prev_hold;
    logic [7:0] prev_data;
    prev_hold = 1'b0;
    prev_data = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        erd       = ewr;
        prev_hold = 1'b0;
      end else begin
        if (fifo_pop) begin
          check("pop_empty", 32'(frd != fwr), 1);
          check("pop_while_valid", 32'(out_valid), 0);
        end
        if (burst_done) begin
          done_cnt++;
          check("done_busy", 32'(busy), 0);
        end
        if (prev_hold) begin
          check("hold_valid", 32'(out_valid), 1);
          check("hold_data", 32'(out_data), 32'(prev_data));
        end
        if (out_valid && out_ready) begin
          check("beat", 32'(out_data), 32'(exp_mem[erd]));
          erd = erd + 12'd1;
          beat_cnt++;
        end
        prev_hold = out_valid && !out_ready;
        prev_data = out_data;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int n);
    for (int i = 0; i < n; i++) begin
      wr_dat    = 8'($urandom);
      fifo_push = 1'b1;
      if (!fifo_full) begin
        exp_mem[ewr] = wr_dat;
        ewr = ewr + 12'd1;
        if (mlevel < 256) mlevel++;
      end
      tick();
      fifo_push = 1'b0;
    end
  endtask

  task automatic cfg_save(input logic [2:0] c);
    configuration = c;
    save_config   = 1'b1;
    tick();
    save_config   = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    check(name, 32'(out_valid), 1);
  endtask

  task automatic wait_done(input string name, input int d0);
    int n = 0;
    while (done_cnt == d0 && n < 3000) begin
      tick();
      n++;
    end
    repeat (2) tick();
    check(name, 32'(done_cnt - d0), 1);
  endtask

  initial begin
    int p0, b0, d0, k;
    logic [7:0] hd;
    reset = 1'b0; configuration = '0; save_config = 1'b0; fifo_push = 1'b0;
    fifo_full = 1'b0; fifo_no_config = 1'b0; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pop", 32'(fifo_pop), 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_data", 32'(out_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(burst_done), 0);
    check("rst_cfg_missing", 32'(cfg_missing), 1);
    check("rst_level", 32'(level), 0);
    reset = 1'b1;
    tick();

    // start before any configuration is dropped
    p0 = pop_cnt;
    pulse_start();
    repeat (5) begin
      tick();
      check("nocfg_busy", 32'(busy), 0);
    end
    check("nocfg_pops", 32'(pop_cnt - p0), 0);
    check("nocfg_missing", 32'(cfg_missing), 1);

    // burst of 4 from 6 queued words, free-flowing sink
    cfg_save(3'd2);
    check("cfg_saved", 32'(cfg_missing), 0);
    push(6);
    check("lvl_after_push", 32'(level), 32'(mlevel));
    p0 = pop_cnt; b0 = beat_cnt; d0 = done_cnt;
    pulse_start();
    k = 0;
    while (k < 10 && !out_valid) begin
      tick();
      k++;
    end
    check("first_valid_latency", 32'(k), 2);
    wait_done("burst4_done", d0);
    mlevel -= 4;
    check("burst4_pops", 32'(pop_cnt - p0), 4);
    check("burst4_beats", 32'(beat_cnt - b0), 4);
    check("burst4_level", 32'(level), 32'(mlevel));

    // backpressure holds the beat and stalls popping
    push(4);
    ready_mode = 2;
    p0 = pop_cnt; b0 = beat_cnt; d0 = done_cnt;
    pulse_start();
    wait_valid("bp_first_valid");
    hd = out_data; k = pop_cnt;
    repeat (5) begin
      tick();
      check("bp_valid", 32'(out_valid), 1);
      check("bp_data", 32'(out_data), 32'(hd));
    end
    check("bp_no_extra_pop", 32'(pop_cnt), 32'(k));
    ready_mode = 0;
    wait_done("bp_done", d0);
    mlevel -= 4;
    check("bp_pops", 32'(pop_cnt - p0), 4);
    check("bp_beats", 32'(beat_cnt - b0), 4);

    // starvation: burst of 8 with only 3 words available
    push(1);
    cfg_save(3'd3);
    p0 = pop_cnt; b0 = beat_cnt; d0 = done_cnt;
    pulse_start();
    k = 0;
    while (beat_cnt - b0 < 3 && k < 200) begin
      tick();
      k++;
    end
    repeat (8) tick();
    check("starve_beats", 32'(beat_cnt - b0), 3);
    check("starve_pops", 32'(pop_cnt - p0), 3);
    check("starve_busy", 32'(busy), 1);
    check("starve_pop_low", 32'(fifo_pop), 0);
    check("starve_level", 32'(level), 0);
    ready_mode = 1;
    push(5);
    wait_done("starve_done", d0);
    ready_mode = 0;
    mlevel -= 8;
    check("starve_total_pops", 32'(pop_cnt - p0), 8);
    check("starve_total_beats", 32'(beat_cnt - b0), 8);
    check("starve_end_level", 32'(level), 32'(mlevel));

    // push and pop landing on the same edge leave the level alone
    cfg_save(3'd0);
    push(2);
    d0 = done_cnt;
    pulse_start();
    k = 0;
    while (!fifo_pop && k < 20) begin
      tick();
      k++;
    end
    check("pp_pop_seen", 32'(fifo_pop), 1);
    push(1);
    check("pp_level_same", 32'(level), 2);
    wait_done("pp_done", d0);
    mlevel -= 1;
    check("pp_level_end", 32'(level), 32'(mlevel));

    // save_config during a burst is ignored
    cfg_save(3'd1);
    push(2);
    ready_mode = 2;
    b0 = beat_cnt; d0 = done_cnt;
    pulse_start();
    wait_valid("busycfg_valid");
    configuration = 3'd5;
    save_config = 1'b1;
    tick();
    save_config = 1'b0;
    ready_mode = 0;
    wait_done("busycfg_done", d0);
    check("busycfg_beats", 32'(beat_cnt - b0), 2);
    b0 = beat_cnt; d0 = done_cnt;
    pulse_start();
    wait_done("busycfg_done2", d0);
    check("busycfg_beats2", 32'(beat_cnt - b0), 2);
    mlevel -= 4;
    check("busycfg_level", 32'(level), 32'(mlevel));

    // fifo_no_config blocks a start but not a running burst
    push(2);
    fifo_no_config = 1'b1;
    pulse_start();
    repeat (3) begin
      tick();
      check("noconf_busy", 32'(busy), 0);
    end
    fifo_no_config = 1'b0;
    b0 = beat_cnt; d0 = done_cnt;
    pulse_start();
    fifo_no_config = 1'b1;
    wait_done("noconf_mid_done", d0);
    fifo_no_config = 1'b0;
    mlevel -= 2;
    check("noconf_mid_beats", 32'(beat_cnt - b0), 2);

    // level saturation: 260 pushes, FIFO reports full after 256
    for (int i = 0; i < 260; i++) begin
      fifo_full = (i >= 256);
      push(1);
    end
    fifo_full = 1'b0;
    check("sat_level", 32'(level), 256);

    // reset asserted mid-HOLD aborts immediately
    ready_mode = 2;
    d0 = done_cnt;
    pulse_start();
    wait_valid("rst_mid_valid");
    reset = 1'b0;
    #1;
    check("midrst_valid", 32'(out_valid), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_level", 32'(level), 0);
    check("midrst_cfg_missing", 32'(cfg_missing), 1);
    check("midrst_done", 32'(burst_done), 0);
    check("midrst_pop", 32'(fifo_pop), 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    ready_mode = 0;
    repeat (3) tick();
    check("midrst_no_done_pulse", 32'(done_cnt - d0), 0);
    pulse_start();
    repeat (3) begin
      tick();
      check("postrst_busy", 32'(busy), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
